// File: rtl/stopwatch_timebase_ctrl_if.sv
// Command channel from the Ethernet-side master controller to the stopwatch
// timebase: 2-bit command code qualified by a valid/ready handshake.
interface stopwatch_timebase_ctrl_if;
   logic       cmd_valid;
   logic [1:0] cmd_code;
   logic       cmd_ready;

   modport master (output cmd_valid, output cmd_code, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_code, output cmd_ready);
endinterface

// File: rtl/stopwatch_timebase_ctrl.sv
// Stopwatch run-control sequencer: accepts START/STOP/LAP/CLEAR commands,
// gates a CLK_HZ->TICK_HZ prescaler and accumulates elapsed time as BCD mm:ss.cc.
module stopwatch_timebase_ctrl #(
   parameter int CLK_HZ  = 25000000,
   parameter int TICK_HZ = 100,
   parameter int MAX_MIN = 59
) (
   input  logic                      twentyFive_mhz_clk,
   input  logic                      reset,
   stopwatch_timebase_ctrl_if.slave  cmd_if,
   output logic [23:0]               o_time_bcd,
   output logic [23:0]               o_lap_bcd,
   output logic                      o_lap_valid,
   output logic                      o_running,
   output logic                      o_overflow,
   output logic                      o_tick_out
);

   localparam int              TICK_DIV   = CLK_HZ / TICK_HZ;
   localparam int              PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   PRESC_TERM = PW'(TICK_DIV - 1);
   localparam logic [23:0]     TIME_MAX   = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 16'h5999};

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE} state_e;
   typedef enum logic [1:0] {CMD_START, CMD_STOP, CMD_LAP, CMD_CLEAR} cmd_e;

   state_e          r_state;
   cmd_e            r_cmd_code;
   logic            r_cmd_pend;
   logic            r_cmd_ready;
   logic [PW-1:0]   r_presc;
   logic [23:0]     r_time;
   logic [23:0]     r_lap;
   logic            r_lap_valid;
   logic            r_running;
   logic            r_overflow;
   logic            r_tick;

   logic            w_terminal;
   logic            w_at_max;
   logic [23:0]     w_time_inc;

   // Digit order from LSB: cs_o, cs_t, sec_o, sec_t (rolls at 5), min_o, min_t.
   function automatic logic [23:0] bcd_inc(input logic [23:0] t);
      logic [23:0] r;
      logic        c;
      r = t;
      c = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (c) begin
            if (r[i*4 +: 4] == ((i == 3) ? 4'd5 : 4'd9)) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               c           = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign w_terminal = (r_presc == PRESC_TERM);
   assign w_at_max   = (r_time == TIME_MAX);
   assign w_time_inc = bcd_inc(r_time);

   assign cmd_if.cmd_ready = r_cmd_ready;
   assign o_time_bcd       = r_time;
   assign o_lap_bcd        = r_lap;
   assign o_lap_valid      = r_lap_valid;
   assign o_running        = r_running;
   assign o_overflow       = r_overflow;
   assign o_tick_out       = r_tick;

   // NOTE: all state below updates with non-blocking assignments so every branch
   // sees the pre-edge values of r_time/r_presc, whatever order the branches run in.
   always_ff @(posedge twentyFive_mhz_clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cmd_code  <= CMD_START;
         r_cmd_pend  <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_presc     <= '0;
         r_time      <= '0;
         r_lap       <= '0;
         r_lap_valid <= 1'b0;
         r_running   <= 1'b0;
         r_overflow  <= 1'b0;
         r_tick      <= 1'b0;
      end else begin
         r_tick      <= 1'b0;
         r_lap_valid <= 1'b0;

         // A captured command executes on the following edge; ready stays low meanwhile.
         if (r_cmd_pend) begin
            r_cmd_pend  <= 1'b0;
            r_cmd_ready <= 1'b1;
         end else if (cmd_if.cmd_valid && r_cmd_ready) begin
            r_cmd_pend  <= 1'b1;
            r_cmd_code  <= cmd_e'(cmd_if.cmd_code);
            r_cmd_ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (r_cmd_pend && r_cmd_code == CMD_START) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
                  r_presc   <= '0;
               end else if (r_cmd_pend && r_cmd_code == CMD_CLEAR) begin
                  r_time  <= '0;
                  r_lap   <= '0;
                  r_presc <= '0;
               end
            end
            ST_RUN: begin
               if (r_cmd_pend && r_cmd_code == CMD_CLEAR) begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
                  r_time    <= '0;
                  r_lap     <= '0;
                  r_presc   <= '0;
               end else if (r_cmd_pend && r_cmd_code == CMD_STOP) begin
                  // The STOP edge does not count, so a pause at terminal count keeps the pending tick.
                  r_state   <= ST_PAUSE;
                  r_running <= 1'b0;
               end else begin
                  if (w_terminal) begin
                     r_presc <= '0;
                     if (w_at_max) begin
                        r_state    <= ST_DONE;
                        r_running  <= 1'b0;
                        r_overflow <= 1'b1;
                     end else begin
                        r_time <= w_time_inc;
                        r_tick <= 1'b1;
                     end
                  end else begin
                     r_presc <= r_presc + PW'(1);
                  end
                  if (r_cmd_pend && r_cmd_code == CMD_LAP) begin
                     r_lap       <= (w_terminal && !w_at_max) ? w_time_inc : r_time;
                     r_lap_valid <= 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (r_cmd_pend && r_cmd_code == CMD_START) begin
                  r_state   <= ST_RUN;
                  r_running <= 1'b1;
               end else if (r_cmd_pend && r_cmd_code == CMD_CLEAR) begin
                  r_state <= ST_IDLE;
                  r_time  <= '0;
                  r_lap   <= '0;
                  r_presc <= '0;
               end
            end
            ST_DONE: begin
               if (r_cmd_pend && r_cmd_code == CMD_CLEAR) begin
                  r_state    <= ST_IDLE;
                  r_overflow <= 1'b0;
                  r_time     <= '0;
                  r_lap      <= '0;
                  r_presc    <= '0;
               end
            end
         endcase
      end
   end

endmodule
